// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Holds the size and state encodings, the wait-state range and the access legality check.
package dmem_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   localparam int LAT_MIN = 2;
   localparam int LAT_MAX = 15;

   function automatic bit latency_ok(input int lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

   // An access is illegal when it is not naturally aligned or uses the reserved size.
   function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
      logic err;
      case (size)
         SIZE_WORD: err = (lo != 2'b00);
         SIZE_HALF: err = lo[0];
         SIZE_BYTE: err = 1'b0;
         SIZE_ILL:  err = 1'b1;
         default:   err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data aligner: moves the addressed lane(s) of a RAM word down to bit 0
// and sign- or zero-extends according to the access size.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted_s;
   logic        hsign_s;
   logic        bsign_s;

   // Lane select followed by extension.
   always_comb begin
      shifted_s = word_i >> {addr_lo_i, 3'b000};
      hsign_s   = ~unsigned_i & shifted_s[15];
      bsign_s   = ~unsigned_i & shifted_s[7];
      case (size_i)
         SIZE_WORD: data_o = word_i;
         SIZE_HALF: data_o = {{16{hsign_s}}, shifted_s[15:0]};
         SIZE_BYTE: data_o = {{24{bsign_s}}, shifted_s[7:0]};
         default:   data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request side, fixed wait states,
// one-cycle response strobe with aligned load data and a misalignment flag.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Mem_Write,
   input  logic [1:0]        Memory_Byte,
   input  logic              Load_Unsigned,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       Data_In,
   output logic              Resp_Valid,
   output logic [31:0]       Data_Out,
   output logic              Misalign_Err
);

   localparam int         DEPTH    = 2 ** (ADDR_W - 2);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

   if (!latency_ok(LATENCY)) begin : g_latency_check
      $error("dmem_responder: LATENCY must be in 2..15");
   end

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       data_out_q, data_out_d;
   logic              err_q, err_d;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       rdata_s;
   logic [31:0]       load_s;
   logic [31:0]       wlanes_s;
   logic [3:0]        be_s;
   logic              err_s;
   logic              access_s;
   logic              we_s;

   // Decode of the latched request: legality, byte enables and replicated store lanes.
   always_comb begin
      err_s   = access_err(size_q, addr_q[1:0]);
      rdata_s = mem[addr_q[ADDR_W-1:2]];
      case (size_q)
         SIZE_BYTE: begin
            be_s     = 4'b0001 << addr_q[1:0];
            wlanes_s = {4{wdata_q[7:0]}};
         end
         SIZE_HALF: begin
            be_s     = addr_q[1] ? 4'b1100 : 4'b0011;
            wlanes_s = {2{wdata_q[15:0]}};
         end
         SIZE_WORD: begin
            be_s     = 4'b1111;
            wlanes_s = wdata_q;
         end
         default: begin
            be_s     = 4'b0000;
            wlanes_s = 32'h0000_0000;
         end
      endcase
   end

   dmem_load_align u_align (
      .word_i     (rdata_s),
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (load_s)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      data_out_d   = 32'h0000_0000;
      err_d        = 1'b0;
      access_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (Req_Valid) begin
               wr_d    = Mem_Write;
               size_d  = Memory_Byte;
               uns_d   = Load_Unsigned;
               addr_d  = Address;
               wdata_d = Data_In;
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access_s     = 1'b1;
               state_d      = RESP;
               resp_valid_d = 1'b1;
               err_d        = err_s;
               data_out_d   = (err_s || wr_q) ? 32'h0000_0000 : load_s;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
      we_s    = access_s & wr_q & ~err_s;
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         wr_q         <= 1'b0;
         size_q       <= SIZE_WORD;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'h0000_0000;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         data_out_q   <= 32'h0000_0000;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         data_out_q   <= data_out_d;
         err_q        <= err_d;
      end
   end

   // RAM lane writes; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we_s && be_s[i]) begin
            mem[addr_q[ADDR_W-1:2]][i*8 +: 8] <= wlanes_s[i*8 +: 8];
         end
      end
   end

   assign Req_Ready    = ready_q;
   assign Resp_Valid   = resp_valid_q;
   assign Data_Out     = data_out_q;
   assign Misalign_Err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY 2 and 5 instances) and the load aligner.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, mem_write = 1'b0, load_uns = 1'b0;
   logic [1:0]  mem_byte = 2'b00;
   logic [8:0]  address = 9'h000;
   logic [31:0] data_in = 32'h0;
   logic        resp_valid, misalign;
   logic [31:0] data_out;

   logic        l_valid = 1'b0, l_ready, l_wr = 1'b0, l_uns = 1'b0;
   logic [1:0]  l_size = 2'b00;
   logic [8:0]  l_addr = 9'h000;
   logic [31:0] l_din = 32'h0;
   logic        l_resp, l_err;
   logic [31:0] l_dout;

   logic [31:0] a_word = 32'h0, a_out;
   logic [1:0]  a_lo = 2'b00, a_size = 2'b00;
   logic        a_uns = 1'b0;

   dmem_responder #(.ADDR_W(9), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .Req_Valid(req_valid), .Req_Ready(req_ready),
      .Mem_Write(mem_write), .Memory_Byte(mem_byte), .Load_Unsigned(load_uns),
      .Address(address), .Data_In(data_in), .Resp_Valid(resp_valid),
      .Data_Out(data_out), .Misalign_Err(misalign));

   dmem_responder #(.ADDR_W(9), .LATENCY(5)) dut5 (
      .clk(clk), .rst(rst), .Req_Valid(l_valid), .Req_Ready(l_ready),
      .Mem_Write(l_wr), .Memory_Byte(l_size), .Load_Unsigned(l_uns),
      .Address(l_addr), .Data_In(l_din), .Resp_Valid(l_resp),
      .Data_Out(l_dout), .Misalign_Err(l_err));

   dmem_load_align u_align_tb (
      .word_i(a_word), .addr_lo_i(a_lo), .size_i(a_size), .unsigned_i(a_uns), .data_o(a_out));

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [8:0]  addr;
      logic [31:0] din;
      logic [31:0] exp_data;
      logic        exp_err;
   } txn_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] obs_data;
   logic        obs_err;
   bit          obs_to;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one request on the LATENCY=2 instance, queue its expectation, capture the response.
   task automatic xfer(input txn_t t);
      exp_t e;
      int   n;
      n = 0;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      mem_write = t.wr;
      mem_byte  = t.size;
      load_uns  = t.uns;
      address   = t.addr;
      data_in   = t.din;
      req_valid = 1'b1;
      e.data = t.exp_data;
      e.err  = t.exp_err;
      e.cyc  = 0;
      exp_q.push_back(e);
      step();
      req_valid = 1'b0;
      obs_to   = 1'b1;
      obs_data = 32'h0;
      obs_err  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid) begin
            obs_to   = 1'b0;
            obs_data = data_out;
            obs_err  = misalign;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      int seen;
      step(); step(); step();
      n_cmp++;
      if (resp_valid !== 1'b0 || data_out !== 32'h0 || misalign !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got rv=%b do=%h err=%b, want 0/0/0", resp_valid, data_out, misalign);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 1", req_ready);
      end
      mem_write = 1'b0; mem_byte = SIZE_WORD; address = 9'h010; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_busy: got ready=%b want 0", req_ready);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (resp_valid !== 1'b0 || data_out !== 32'h0 || misalign !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inflight: got rv=%b do=%h err=%b, want 0/0/0", resp_valid, data_out, misalign);
      end
      step();
      rst = 1'b0;
      step();
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b want 1", req_ready);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid) seen++;
         step();
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL dropped_resp: got %0d responses want 0", seen);
      end
   endtask

   task automatic test_word();
      exp_t e;
      txn_t t;
      while (!req_ready) step();
      mem_write = 1'b1; mem_byte = SIZE_WORD; load_uns = 1'b0;
      address = 9'h010; data_in = 32'h1234_5678; req_valid = 1'b1;
      e.data = 32'h0; e.err = 1'b0; e.cyc = 0;
      exp_q.push_back(e);
      step();
      req_valid = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL word_t1: got ready=%b rv=%b want 0/0", req_ready, resp_valid);
      end
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || data_out !== e.data || misalign !== e.err) begin
         n_fail++;
         $display("FAIL word_t2: got rv=%b ready=%b do=%h err=%b, want 1/0/%h/%b",
                  resp_valid, req_ready, data_out, misalign, e.data, e.err);
      end
      step();
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || data_out !== 32'h0) begin
         n_fail++;
         $display("FAIL word_t3: got rv=%b ready=%b do=%h, want 0/1/0", resp_valid, req_ready, data_out);
      end
      t = '{1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, 32'h1234_5678, 1'b0};
      xfer(t);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_to || obs_data !== e.data || obs_err !== e.err) begin
         n_fail++;
         $display("FAIL word_load: got do=%h err=%b to=%b, want %h/%b", obs_data, obs_err, obs_to, e.data, e.err);
      end
   endtask

   task automatic test_byte();
      txn_t t[4];
      exp_t e;
      t[0] = '{1'b1, SIZE_BYTE, 1'b0, 9'h013, 32'h0000_00AB, 32'h0, 1'b0};
      t[1] = '{1'b0, SIZE_BYTE, 1'b0, 9'h013, 32'h0, 32'hFFFF_FFAB, 1'b0};
      t[2] = '{1'b0, SIZE_BYTE, 1'b1, 9'h013, 32'h0, 32'h0000_00AB, 1'b0};
      t[3] = '{1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, 32'hAB34_5678, 1'b0};
      foreach (t[i]) begin
         xfer(t[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_to || obs_data !== e.data || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL byte[%0d]: got do=%h err=%b to=%b, want %h/%b", i, obs_data, obs_err, obs_to, e.data, e.err);
         end
      end
   endtask

   task automatic test_half();
      txn_t t[5];
      exp_t e;
      t[0] = '{1'b1, SIZE_WORD, 1'b0, 9'h014, 32'h0000_BEEF, 32'h0, 1'b0};
      t[1] = '{1'b1, SIZE_HALF, 1'b0, 9'h016, 32'h0000_8001, 32'h0, 1'b0};
      t[2] = '{1'b0, SIZE_HALF, 1'b0, 9'h016, 32'h0, 32'hFFFF_8001, 1'b0};
      t[3] = '{1'b0, SIZE_HALF, 1'b1, 9'h016, 32'h0, 32'h0000_8001, 1'b0};
      t[4] = '{1'b0, SIZE_WORD, 1'b0, 9'h014, 32'h0, 32'h8001_BEEF, 1'b0};
      foreach (t[i]) begin
         xfer(t[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_to || obs_data !== e.data || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL half[%0d]: got do=%h err=%b to=%b, want %h/%b", i, obs_data, obs_err, obs_to, e.data, e.err);
         end
      end
   endtask

   task automatic test_misalign();
      txn_t t[7];
      exp_t e;
      t[0] = '{1'b1, SIZE_WORD, 1'b0, 9'h012, 32'hFFFF_FFFF, 32'h0, 1'b1};
      t[1] = '{1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, 32'hAB34_5678, 1'b0};
      t[2] = '{1'b0, SIZE_ILL,  1'b0, 9'h010, 32'h0, 32'h0, 1'b1};
      t[3] = '{1'b0, SIZE_HALF, 1'b0, 9'h011, 32'h0, 32'h0, 1'b1};
      t[4] = '{1'b1, SIZE_ILL,  1'b0, 9'h010, 32'hDEAD_BEEF, 32'h0, 1'b1};
      t[5] = '{1'b0, SIZE_WORD, 1'b0, 9'h010, 32'h0, 32'hAB34_5678, 1'b0};
      t[6] = '{1'b0, SIZE_BYTE, 1'b0, 9'h011, 32'h0, 32'h0000_0056, 1'b0};
      foreach (t[i]) begin
         xfer(t[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_to || obs_data !== e.data || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL misalign[%0d]: got do=%h err=%b to=%b, want %h/%b", i, obs_data, obs_err, obs_to, e.data, e.err);
         end
      end
   endtask

   task automatic test_latency();
      exp_t e;
      int   last_acc;
      int   nresp;
      int   n;
      last_acc = -1;
      nresp = 0;
      n = 0;
      while (!l_ready && n < 50) begin
         step();
         n++;
      end
      l_wr = 1'b1; l_size = SIZE_WORD; l_addr = 9'h020; l_din = 32'h5555_AAAA; l_valid = 1'b1;
      for (int c = 0; c < 32; c++) begin
         if (c == 24) l_valid = 1'b0;
         if (l_resp) begin
            nresp++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL lat_extra: response at cycle %0d with nothing outstanding", c);
            end else begin
               e = exp_q.pop_front();
               if (c != e.cyc + 5 || l_dout !== 32'h0 || l_err !== 1'b0) begin
                  n_fail++;
                  $display("FAIL lat_resp: got cycle=%0d do=%h err=%b, want cycle=%0d do=0 err=0",
                           c, l_dout, l_err, e.cyc + 5);
               end
            end
         end
         if (l_valid && l_ready) begin
            if (last_acc >= 0) begin
               n_cmp++;
               if (c - last_acc != 6) begin
                  n_fail++;
                  $display("FAIL lat_accept: got spacing %0d want 6", c - last_acc);
               end
            end
            last_acc = c;
            e.cyc = c; e.data = 32'h0; e.err = 1'b0;
            exp_q.push_back(e);
         end
         step();
      end
      n_cmp++;
      if (nresp !== 4 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL lat_count: got %0d responses, %0d pending, want 4 and 0", nresp, exp_q.size());
      end
   endtask

   task automatic test_align();
      logic [31:0] w;
      logic [1:0]  lo[7];
      logic [1:0]  sz[7];
      logic        un[7];
      logic [31:0] ex[7];
      w = 32'h8081_F27F;
      lo[0] = 2'd0; sz[0] = SIZE_BYTE; un[0] = 1'b0; ex[0] = 32'h0000_007F;
      lo[1] = 2'd1; sz[1] = SIZE_BYTE; un[1] = 1'b0; ex[1] = 32'hFFFF_FFF2;
      lo[2] = 2'd2; sz[2] = SIZE_BYTE; un[2] = 1'b0; ex[2] = 32'hFFFF_FF81;
      lo[3] = 2'd3; sz[3] = SIZE_BYTE; un[3] = 1'b1; ex[3] = 32'h0000_0080;
      lo[4] = 2'd2; sz[4] = SIZE_HALF; un[4] = 1'b0; ex[4] = 32'hFFFF_8081;
      lo[5] = 2'd0; sz[5] = SIZE_HALF; un[5] = 1'b1; ex[5] = 32'h0000_F27F;
      lo[6] = 2'd0; sz[6] = SIZE_WORD; un[6] = 1'b0; ex[6] = 32'h8081_F27F;
      for (int i = 0; i < 7; i++) begin
         a_word = w; a_lo = lo[i]; a_size = sz[i]; a_uns = un[i];
         #1;
         n_cmp++;
         if (a_out !== ex[i]) begin
            n_fail++;
            $display("FAIL align[%0d]: got %h want %h", i, a_out, ex[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misalign();
      test_latency();
      test_align();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts load/store requests (word, halfword or byte) through a valid/ready handshake.
- Inserts a fixed, configurable number of wait states.
- Returns lane-aligned, sign- or zero-extended load data, and flags misaligned or illegal accesses.
- Sits between the CPU load/store path and on-chip data RAM; it is the multi-cycle replacement for the combinational data memory.

Parameters:
- ADDR_W, 9, byte-address width; storage depth is 2^(ADDR_W-2) 32-bit words (128 at default).
- LATENCY, 2, cycles from request acceptance to Resp_Valid; legal range 2..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- Req_Valid  in  1  request present
- Req_Ready  out  1  responder can accept; high exactly when state is IDLE
- Mem_Write  in  1  1 = store, 0 = load
- Memory_Byte  in  2  size: 00 word, 01 halfword, 10 byte, 11 illegal
- Load_Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend; ignored for word and store
- Address  in  ADDR_W  byte address
- Data_In  in  32  store data, right-justified
- Resp_Valid  out  1  one-cycle response strobe; no back-pressure
- Data_Out  out  32  load result, valid only while Resp_Valid is high, else 0
- Misalign_Err  out  1  high with Resp_Valid when the access was rejected

Behaviour:
- Reset (async, any state): state IDLE, wait counter 0, latched request cleared.
  - Resp_Valid=0, Data_Out=0, Misalign_Err=0; Req_Ready=1 once rst is released.
  - RAM contents are not reset; a store in flight when reset asserts is dropped.
- State machine:
  - IDLE: Req_Ready=1. On Req_Valid at the edge, latch Mem_Write, Memory_Byte, Load_Unsigned, Address, Data_In; counter <= LATENCY-2; go to WAIT.
  - WAIT: Req_Ready=0; request inputs are ignored. If counter != 0, decrement; if counter == 0, perform the access at this edge and go to RESP.
  - RESP: Resp_Valid=1 for exactly one cycle, Req_Ready=0; next edge goes to IDLE.
- Timing: request accepted in cycle t gives Resp_Valid in cycle t+LATENCY. Back-to-back requests therefore issue every LATENCY+1 cycles.
- Access at the WAIT->RESP edge uses only the latched request:
  - Word index is Address[ADDR_W-1:2]; byte order is little-endian, so lane 0 is bits 7:0.
  - Byte store: writes lane Address[1:0] with Data_In[7:0]; other lanes are unchanged.
  - Halfword store: writes lanes {Address[1],0} and {Address[1],1} with Data_In[15:0].
  - Word store: writes all four lanes.
  - Store response: Data_Out=0.
  - Load: read the word, shift the selected lane(s) to bit 0, then extend per Load_Unsigned. A word load returns the word unchanged.
- Error cases:
  - Conditions: halfword with Address[0]=1, word with Address[1:0]!=0, or Memory_Byte=11.
  - Response: no RAM write, Data_Out=0, Misalign_Err=1 during RESP.
- A store followed by a load to the same word returns the new data; the RAM is written before the later request is accepted.
- Data_Out and Misalign_Err are registered and return to 0 the cycle after RESP.

Decomposition:
- Package dmem_pkg holds:
  - size encodings: SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10;
  - state encodings: IDLE, WAIT, RESP;
  - the LATENCY range check constant.
- Sub-module dmem_load_align (combinational) takes raw word, Address[1:0], size and Load_Unsigned, and produces the extended result. It is instantiated once and tested standalone.
- The byte-enable generation for stores stays inline.

Test Plan:
- Reset: pulse rst while a load is in WAIT -> Resp_Valid never asserts, Data_Out=0, Misalign_Err=0, Req_Ready=1 the cycle after rst falls.
- Word store then load:
  - Store 0x12345678 to 0x010, accepted in cycle t -> Resp_Valid in cycle t+2, Req_Ready low in t+1 and t+2.
  - Word load of 0x010 -> Data_Out=0x12345678.
- Byte store 0xAB to 0x013:
  - Signed byte load of 0x013 -> 0xFFFFFFAB.
  - Unsigned byte load of 0x013 -> 0x000000AB.
  - Word load of 0x010 -> 0xAB345678.
- Halfword store 0x8001 to 0x016:
  - Signed half load of 0x016 -> 0xFFFF8001.
  - Unsigned half load of 0x016 -> 0x00008001.
  - Word load of 0x014 -> bits 31:16 = 0x8001, bits 15:0 unchanged.
- Misalign:
  - Word store to 0x012 -> Misalign_Err=1, Data_Out=0; a later word load of 0x010 still returns 0xAB345678.
  - Memory_Byte=11 -> Misalign_Err=1.
- Latency and busy handling, with LATENCY=5 and Req_Valid held high continuously -> accept in cycle t, Resp_Valid in t+5, next accept in t+6; requests presented while busy cause no extra responses.
